// File: rtl/alu_seq_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the ALU op sequencer.
// Opcodes 10-15 are outside the ALU's range and are treated as illegal by the sequencer.
package alu_seq_pkg;

   localparam logic [3:0] OP_AND  = 4'd0;
   localparam logic [3:0] OP_OR   = 4'd1;
   localparam logic [3:0] OP_ADD  = 4'd2;
   localparam logic [3:0] OP_INC  = 4'd3;
   localparam logic [3:0] OP_DEC  = 4'd4;
   localparam logic [3:0] OP_NOT  = 4'd5;
   localparam logic [3:0] OP_SUB  = 4'd6;
   localparam logic [3:0] OP_XOR  = 4'd7;
   localparam logic [3:0] OP_SHL  = 4'd8;
   localparam logic [3:0] OP_SHR  = 4'd9;
   localparam logic [3:0] OP_LAST = 4'd9;

   localparam int FLAG_ZERO  = 1;
   localparam int FLAG_CARRY = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } seq_state_t;

   function automatic logic op_is_legal(input logic [3:0] op);
      return (op <= OP_LAST);
   endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Sequences one command at a time through an external ALUparam with an N-bit accumulator.
// Optional macro ALU_SEQ_CARRY_CHAIN_EN chains ALU carry-out into the flag-in of ADD/SUB.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [3:0]   cmd_op,
   input  logic [N-1:0] cmd_a,
   input  logic [N-1:0] cmd_b,
   input  logic         cmd_flagin,
   input  logic         cmd_use_acc,
   output logic [N-1:0] ALUA,
   output logic [N-1:0] ALUB,
   output logic [3:0]   ALUcontrol,
   output logic         ALUFLAGin,
   input  logic [N-1:0] ALUresult,
   input  logic [1:0]   ALUflags,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [N-1:0] res_data,
   output logic         res_zero,
   output logic         res_carry,
   output logic         res_err
);

   seq_state_t   state_reg;
   logic [N-1:0] acc_reg;
   logic         legal_reg;
   logic         exec_wait_reg;
   logic         flagin_next;

`ifdef ALU_SEQ_CARRY_CHAIN_EN
   logic         carry_reg;
`endif

   // Flag-in is chosen at accept time so it is registered alongside the operands.
   always_comb begin
      flagin_next = cmd_flagin;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
      if (cmd_op == OP_ADD || cmd_op == OP_SUB) begin
         flagin_next = carry_reg;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         cmd_ready     <= 1'b1;
         res_valid     <= 1'b0;
         res_data      <= '0;
         res_zero      <= 1'b0;
         res_carry     <= 1'b0;
         res_err       <= 1'b0;
         ALUA          <= '0;
         ALUB          <= '0;
         ALUcontrol    <= '0;
         ALUFLAGin     <= 1'b0;
         acc_reg       <= '0;
         legal_reg     <= 1'b0;
         exec_wait_reg <= 1'b0;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
         carry_reg     <= 1'b0;
`endif
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (cmd_valid) begin
                  ALUA          <= cmd_use_acc ? acc_reg : cmd_a;
                  ALUB          <= cmd_b;
                  ALUcontrol    <= cmd_op;
                  ALUFLAGin     <= flagin_next;
                  legal_reg     <= op_is_legal(cmd_op);
                  exec_wait_reg <= 1'b1;
                  cmd_ready     <= 1'b0;
                  state_reg     <= ST_EXEC;
               end
            end

            // EXEC spans two cycles: the first lets the registered operands settle
            // through the ALU, the second captures its result.
            ST_EXEC: begin
               if (exec_wait_reg) begin
                  exec_wait_reg <= 1'b0;
               end else begin
                  if (legal_reg) begin
                     res_data  <= ALUresult;
                     res_zero  <= ALUflags[FLAG_ZERO];
                     res_carry <= ALUflags[FLAG_CARRY];
                     res_err   <= 1'b0;
                     acc_reg   <= ALUresult;
`ifdef ALU_SEQ_CARRY_CHAIN_EN
                     carry_reg <= ALUflags[FLAG_CARRY];
`endif
                  end else begin
                     res_data  <= '0;
                     res_zero  <= 1'b1;
                     res_carry <= 1'b0;
                     res_err   <= 1'b1;
                  end
                  res_valid <= 1'b1;
                  state_reg <= ST_DONE;
               end
            end

            ST_DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state_reg <= ST_IDLE;
               end
            end

            default: begin
               res_valid <= 1'b0;
               cmd_ready <= 1'b1;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter: N, 4, operand/result width; must match the downstream ALUparam width.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: cmd_valid  input  1  command offered.
REQ-005 SHALL have port: cmd_ready  output  1  command accepted when cmd_valid&&cmd_ready.
REQ-006 SHALL have port: cmd_op  input  4  ALU opcode 0-9.
REQ-007 SHALL have port: cmd_a, cmd_b  input  N each  operands.
REQ-008 SHALL have port: cmd_flagin  input  1  carry-in/operand-select/fill bit.
REQ-009 SHALL have port: cmd_use_acc  input  1  replace cmd_a with the accumulator.
REQ-010 SHALL have port: ALUA, ALUB  output  N each  registered operands to ALU.
REQ-011 SHALL have port: ALUcontrol  output  4  registered opcode; ALUFLAGin  output  1  registered flag-in.
REQ-012 SHALL have port: ALUresult  input  N; ALUflags  input  2  ([1]=zero, [0]=carry/last bit).
REQ-013 SHALL have port: res_valid  output  1; res_ready  input  1; res_data  output  N; res_zero, res_carry, res_err  output  1 each.

Function
REQ-014 SHALL implement FSM IDLE -> EXEC -> DONE -> IDLE; cmd_ready=1 only in IDLE.
REQ-015 SHALL, on accept in IDLE, register ALUA (accumulator if cmd_use_acc else cmd_a), ALUB, ALUcontrol, ALUFLAGin, and enter EXEC.
REQ-016 SHALL hold ALU drive outputs stable from EXEC until the next accept.
REQ-017 SHALL, at end of EXEC, capture ALUresult/ALUflags into res_data/res_zero/res_carry, write ALUresult into the accumulator, and enter DONE.
REQ-018 SHALL assert res_valid only in DONE; latency accept edge -> res_valid is exactly 2 cycles.
REQ-019 SHALL hold res_* stable while res_valid&&!res_ready; return to IDLE on res_valid&&res_ready.
REQ-020 SHALL treat cmd_op 10-15 as illegal: accepted, ALU not consulted, res_data=0, res_zero=1, res_carry=0, res_err=1, accumulator unchanged.
REQ-021 SHALL keep res_err=0 for legal ops.
REQ-022 SHALL ignore cmd_valid outside IDLE; no queuing, no command lost since cmd_ready=0.
REQ-023 SHALL keep accumulator width N; wrap is the ALU's, never extended.

Reset
REQ-024 SHALL on rst_n=0 asynchronously force: state IDLE, cmd_ready=1 after release, res_valid=0, res_data=0, res_zero=0, res_carry=0, res_err=0, ALUA=ALUB=0, ALUcontrol=0, ALUFLAGin=0, accumulator=0, carry register=0.
REQ-025 SHALL discard any in-flight command when reset asserts in EXEC or DONE.

Configuration
REQ-026 SHALL, with ALU_SEQ_CARRY_CHAIN_EN defined, keep a carry register loaded from ALUflags[0] on every legal capture and drive ALUFLAGin from it instead of cmd_flagin when cmd_op is 2 (ADD) or 6 (SUB).
REQ-027 SHALL, without ALU_SEQ_CARRY_CHAIN_EN, drive ALUFLAGin from cmd_flagin for all ops and contain no carry register.

Structure
REQ-028 SHALL take from package alu_seq_pkg: opcode constants OP_AND=0, OP_OR=1, OP_ADD=2, OP_INC=3, OP_DEC=4, OP_NOT=5, OP_SUB=6, OP_XOR=7, OP_SHL=8, OP_SHR=9, OP_LAST=9, flag indices FLAG_ZERO=1, FLAG_CARRY=0, and the FSM state enum.
REQ-029 SHALL instantiate no sub-module; ALUparam is connected beside it at the next level up.

Verification (N=4, bench instantiates ALUparam as the ALU)
REQ-030 SHALL cover: ADD a=3 b=5 flagin=0 accepted at edge t -> res_valid at t+2, res_data=8, zero=0, carry=0.
REQ-031 SHALL cover: ADD a=15 b=1 flagin=0 -> res_data=0, zero=1, carry=1; with ALU_SEQ_CARRY_CHAIN_EN, next ADD a=0 b=0 cmd_flagin=0 -> res_data=1.
REQ-032 SHALL cover: INC a=7 then INC cmd_use_acc=1 -> res_data 8 then 9; accumulator=9.
REQ-033 SHALL cover: res_ready=0 for 5 cycles after res_valid -> res_* unchanged, cmd_ready=0, new cmd_valid ignored.
REQ-034 SHALL cover: cmd_op=12 -> res_err=1, res_data=0, res_zero=1, accumulator unchanged.
REQ-035 SHALL cover: rst_n low during EXEC -> all outputs at reset values immediately, no res_valid after release.
